// File: rtl/dct_pkg.sv
// Shared definitions for the floating-point DCT datapath: word sizing,
// pairing modes, FSM state encoding and the FP zero pattern.
package dct_pkg;

   function automatic int word_w(input int m, input int e);
      return m + e + 1;
   endfunction

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   localparam logic MODE_MIRROR = 1'b0;
   localparam logic MODE_ADJ    = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [63:0] ZERO = 64'h0;

endpackage

// File: rtl/msps_pipe_addsub.sv
// Combinational floating-point add/sub unit: x2 = x1 + y1, y2 = x1 - y1.
// Round-to-nearest-even, gradual underflow, overflow saturates to infinity.
module addsub
   import dct_pkg::*;
#(
   parameter  int M = 23,
   parameter  int E = 8,
   localparam int W = word_w(M, E)
)(
   input  logic [W-1:0] x1,
   input  logic [W-1:0] y1,
   output logic [W-1:0] x2,
   output logic [W-1:0] y2
);

   localparam int FW = M + 5;   // carry, hidden bit, M fraction bits, guard/round/sticky
   localparam int XW = E + 2;
   localparam logic [XW-1:0] EMAX = XW'((1 << E) - 1);

   function automatic logic [W-1:0] round_pack(input logic s, input logic [XW-1:0] x,
                                                input logic [FW-1:0] f);
      logic [M+1:0]  mant;
      logic [XW-1:0] xr;
      logic          up;
      up   = f[2] & (f[1] | f[0] | f[3]);
      mant = {1'b0, f[M+3:3]} + (M+2)'(up);
      xr   = x;
      if (mant[M+1]) begin
         mant = mant >> 1;
         xr   = xr + XW'(1);
      end
      if (xr >= EMAX) return {s, {E{1'b1}}, {M{1'b0}}};
      if (!mant[M])   return {s, {E{1'b0}}, mant[M-1:0]};
      return {s, xr[E-1:0], mant[M-1:0]};
   endfunction

   function automatic logic [W-1:0] fp_add(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0]  p, q;
      logic [XW-1:0] xp, xq, d, xr;
      logic [FW-1:0] fp_w, fq_w, fs;
      // p carries the larger magnitude, so the result takes its sign
      if (a[W-2:0] < b[W-2:0]) begin
         p = b; q = a;
      end else begin
         p = a; q = b;
      end
      xp   = (p[W-2:M] == '0) ? XW'(1) : {2'b00, p[W-2:M]};
      xq   = (q[W-2:M] == '0) ? XW'(1) : {2'b00, q[W-2:M]};
      fp_w = {1'b0, (p[W-2:M] != '0), p[M-1:0], 3'b000};
      fq_w = {1'b0, (q[W-2:M] != '0), q[M-1:0], 3'b000};
      d    = xp - xq;
      for (int i = 0; i < FW; i++)
         if (i < int'(d)) fq_w = {1'b0, fq_w[FW-1:2], fq_w[1] | fq_w[0]};
      if (p[W-1] == q[W-1]) fs = fp_w + fq_w;
      else                  fs = fp_w - fq_w;
      if (fs == '0) return '0;
      xr = xp;
      if (fs[FW-1]) begin
         fs = {1'b0, fs[FW-1:2], fs[1] | fs[0]};
         xr = xr + XW'(1);
      end else begin
         for (int i = 0; i < M + 3; i++)
            if (!fs[M+3] && (xr > XW'(1))) begin
               fs = fs << 1;
               xr = xr - XW'(1);
            end
      end
      return round_pack(p[W-1], xr, fs);
   endfunction

   assign x2 = fp_add(x1, y1);
   assign y2 = fp_add(x1, {~y1[W-1], y1[W-2:0]});

endmodule

// File: rtl/msps_pipe.sv
// Pipelined mirrored/adjacent sum-difference butterfly stage: snapshots the
// input vector, issues LANES pairs per cycle and writes results back into cache.
module msps_pipe
   import dct_pkg::*;
#(
   parameter int M         = 23,
   parameter int E         = 8,
   parameter int DCT_POINT = 16,
   parameter int LANES     = 1,
   parameter int ADD_LAT   = 0
)(
   input  logic                                 clk,
   input  logic                                 clr,
   input  logic                                 start,
   input  logic                                 mode,
   input  logic [word_w(M, E)*DCT_POINT-1:0]    inp,
   output logic [word_w(M, E)*DCT_POINT-1:0]    cache,
   output logic                                 busy,
   output logic                                 msps_f
);

   localparam int W  = word_w(M, E);
   localparam int N  = DCT_POINT;
   localparam int H  = N / 2;
   localparam int P  = H / LANES;
   localparam int L  = P + 1 + ADD_LAT;
   localparam int IW = $clog2(N);
   localparam int CW = $clog2(L + 1);

   if (!is_pow2(N) || (N < 2) || !is_pow2(LANES) || ((H % LANES) != 0) || (ADD_LAT < 0))
   begin : g_bad_params
      $error("msps_pipe: DCT_POINT must be a power of 2 >= 2 and LANES a power of 2 dividing DCT_POINT/2");
   end

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q;
   logic           mode_q;
   logic [W-1:0]   snap_q [N];
   logic           accept, last, issue;

   logic [W-1:0]   opa_c [LANES], opb_c [LANES];
   logic [IW-1:0]  sidx_c [LANES], didx_c [LANES];
   logic [W-1:0]   opa_p0 [LANES], opb_p0 [LANES];
   logic [IW-1:0]  sidx_p0 [LANES], didx_p0 [LANES];
   logic           vld_p0;
   logic [W-1:0]   sum_c [LANES], dif_c [LANES];

   logic [W-1:0]   sum_wb [LANES], dif_wb [LANES];
   logic [IW-1:0]  sidx_wb [LANES], didx_wb [LANES];
   logic           vld_wb;
   logic [W-1:0]   cache_q [N];

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         msps_f  <= 1'b0;
      end else begin
         state_q <= state_d;
         msps_f  <= last;
         if (accept || last)      cnt_q <= '0;
         else if (state_q == RUN) cnt_q <= cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         mode_q <= mode;
         for (int i = 0; i < N; i++) snap_q[i] <= inp[W*i +: W];
      end
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      last    = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            accept  = 1'b1;
            state_d = RUN;
         end
         RUN: if (cnt_q == CW'(L - 1)) begin
            last    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state_q == RUN);
      issue = (state_q == RUN) && (cnt_q < CW'(P));
   end

   // Operand selection: group index is the run counter while issuing
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         int k;
         k = int'(cnt_q) * LANES + l;
         if (mode_q == MODE_ADJ) begin
            opa_c[l]  = snap_q[IW'(2 * k)];
            opb_c[l]  = snap_q[IW'(2 * k + 1)];
            sidx_c[l] = IW'(k);
            didx_c[l] = IW'(H + k);
         end else begin
            opa_c[l]  = snap_q[IW'(H - 1 - k)];
            opb_c[l]  = snap_q[IW'(H + k)];
            sidx_c[l] = IW'(N - 1 - k);
            didx_c[l] = IW'(H - 1 - k);
         end
      end
   end

   // ---- stage p0: operand registers feeding the add/sub units ----
   always_ff @(posedge clk) begin
      if (clr) vld_p0 <= 1'b0;
      else     vld_p0 <= issue;
   end

   always_ff @(posedge clk) begin
      for (int l = 0; l < LANES; l++) begin
         opa_p0[l]  <= opa_c[l];
         opb_p0[l]  <= opb_c[l];
         sidx_p0[l] <= sidx_c[l];
         didx_p0[l] <= didx_c[l];
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      addsub #(.M(M), .E(E)) u_addsub (
         .x1 (opa_p0[l]),
         .y1 (opb_p0[l]),
         .x2 (sum_c[l]),
         .y2 (dif_c[l])
      );
   end

   // ---- stages p1..pADD_LAT: result delay line with destination and valid ----
   if (ADD_LAT > 0) begin : g_dl
      logic [W-1:0]       sum_dl  [ADD_LAT][LANES];
      logic [W-1:0]       dif_dl  [ADD_LAT][LANES];
      logic [IW-1:0]      sidx_dl [ADD_LAT][LANES];
      logic [IW-1:0]      didx_dl [ADD_LAT][LANES];
      logic [ADD_LAT-1:0] vld_dl;

      always_ff @(posedge clk) begin
         if (clr) vld_dl <= '0;
         else begin
            vld_dl[0] <= vld_p0;
            for (int s = 1; s < ADD_LAT; s++) vld_dl[s] <= vld_dl[s-1];
         end
      end

      always_ff @(posedge clk) begin
         for (int l = 0; l < LANES; l++) begin
            sum_dl[0][l]  <= sum_c[l];
            dif_dl[0][l]  <= dif_c[l];
            sidx_dl[0][l] <= sidx_p0[l];
            didx_dl[0][l] <= didx_p0[l];
            for (int s = 1; s < ADD_LAT; s++) begin
               sum_dl[s][l]  <= sum_dl[s-1][l];
               dif_dl[s][l]  <= dif_dl[s-1][l];
               sidx_dl[s][l] <= sidx_dl[s-1][l];
               didx_dl[s][l] <= didx_dl[s-1][l];
            end
         end
      end

      always_comb begin
         vld_wb = vld_dl[ADD_LAT-1];
         for (int l = 0; l < LANES; l++) begin
            sum_wb[l]  = sum_dl[ADD_LAT-1][l];
            dif_wb[l]  = dif_dl[ADD_LAT-1][l];
            sidx_wb[l] = sidx_dl[ADD_LAT-1][l];
            didx_wb[l] = didx_dl[ADD_LAT-1][l];
         end
      end
   end else begin : g_nodl
      always_comb begin
         vld_wb = vld_p0;
         for (int l = 0; l < LANES; l++) begin
            sum_wb[l]  = sum_c[l];
            dif_wb[l]  = dif_c[l];
            sidx_wb[l] = sidx_p0[l];
            didx_wb[l] = didx_p0[l];
         end
      end
   end

   // ---- write-back: each lane updates its two destination words ----
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < N; i++) cache_q[i] <= W'(ZERO);
      end else if (vld_wb) begin
         for (int l = 0; l < LANES; l++) begin
            cache_q[sidx_wb[l]] <= sum_wb[l];
            cache_q[didx_wb[l]] <= dif_wb[l];
         end
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_out
      assign cache[W*i +: W] = cache_q[i];
   end

endmodule
